// File: rtl/fetch_queue.sv
// Instruction fetch unit: one-outstanding-request memory sequencer feeding a
// small FIFO of {pc, instr} pairs that the decode stage drains.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       redirect,
   input  logic [31:0]                redirect_pc,
   input  logic                       deq,
   output logic                       imem_req,
   output logic [31:0]                imem_addr,
   input  logic                       imem_ack,
   input  logic [31:0]                imem_rdata,
   output logic                       valid,
   output logic [31:0]                instr,
   output logic [31:0]                pc,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [31:0]   NOP  = 32'h0000_0013;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] DROP = 2'd2;

   logic [1:0]    state;
   logic [31:0]   fetch_pc;
   logic [31:0]   pc_q    [DEPTH];
   logic [31:0]   instr_q [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [CW-1:0] count_q;

   logic          push;
   logic          pop;
   logic [CW-1:0] count_next;
   logic [31:0]   redirect_word;

   always_comb begin
      redirect_word = redirect_pc & ~32'h0000_0003;
      pop           = deq && (count_q != '0);
      push          = (state == REQ) && imem_ack && !redirect;
      count_next    = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
   end

   // Storage carries no reset; only entries between head and tail are ever observed.
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         pc_q[tail]    <= imem_addr;
         instr_q[tail] <= imem_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         fetch_pc  <= RESET_PC;
         imem_addr <= RESET_PC;
         head      <= '0;
         tail      <= '0;
         count_q   <= '0;
      end else if (redirect) begin
         head     <= '0;
         tail     <= '0;
         count_q  <= '0;
         fetch_pc <= redirect_word;
         // An unacked request must run to completion in DROP so the address stays stable.
         case (state)
            DROP: begin
               if (imem_ack) begin
                  state     <= REQ;
                  imem_addr <= redirect_word;
               end
            end
            REQ: begin
               if (imem_ack) begin
                  imem_addr <= redirect_word;
               end else begin
                  state <= DROP;
               end
            end
            default: begin
               state     <= REQ;
               imem_addr <= redirect_word;
            end
         endcase
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         count_q <= count_next;
         case (state)
            IDLE: begin
               if (count_next < FULL) begin
                  state     <= REQ;
                  imem_addr <= fetch_pc;
               end
            end
            REQ: begin
               if (imem_ack) begin
                  fetch_pc <= fetch_pc + 32'd4;
                  if (count_next < FULL) begin
                     imem_addr <= fetch_pc + 32'd4;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            DROP: begin
               if (imem_ack) begin
                  state     <= REQ;
                  imem_addr <= fetch_pc;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign imem_req = (state == REQ) || (state == DROP);
   assign valid    = (count_q != '0);
   assign count    = count_q;
   assign instr    = valid ? instr_q[head] : NOP;
   assign pc       = valid ? pc_q[head] : 32'h0000_0000;

endmodule
